// File: rtl/raven_ctrl_pkg.sv
// Shared types and opcode constants for the RAVEN PE-row control blocks.
package raven_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        STREAM,
        DRAIN,
        DONE
    } seq_state_e;

    localparam logic [1:0] OP_GEMM = 2'b00;
    localparam logic [1:0] OP_DIV  = 2'b01;
    localparam logic [1:0] OP_EXP  = 2'b10;
    localparam logic [1:0] OP_LOG  = 2'b11;

endpackage

// File: rtl/valid_dly.sv
// Valid-bit delay line modelling the PE row latency, with a GEMM tap and a
// longer unary tap.
module valid_dly #(
    parameter int NUM_PE  = 8,
    parameter int UNO_LAT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic din,
    input  logic uno,
    output logic dout,
    output logic empty
);

    localparam int DEPTH = NUM_PE + UNO_LAT;
    localparam int TAP_G = NUM_PE - 1;
    localparam int TAP_U = DEPTH - 1;

    logic [DEPTH-1:0] sr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else if (clr) begin
            sr_q <= '0;
        end else begin
            sr_q <= (sr_q << 1) | DEPTH'(din);
        end
    end

    assign dout = uno ? sr_q[TAP_U] : sr_q[TAP_G];

    // "Empty" looks only upstream of the active tap: when it is set, the bit
    // at the tap (if any) is the last result, so DRAIN can leave this cycle.
    always_comb begin
        empty = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            if (i < (uno ? TAP_U : TAP_G) && sr_q[i]) begin
                empty = 1'b0;
            end
        end
    end

endmodule

// File: rtl/raven_pe_seq.sv
// Command sequencer for one RAVEN PE row: weight preload, input streaming,
// latency tracking of row results and completion signalling.
module raven_pe_seq
    import raven_ctrl_pkg::*;
#(
    parameter int NUM_PE  = 8,
    parameter int UNO_LAT = 1,
    parameter int LEN_BW  = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [LEN_BW-1:0] cmd_len,
    input  logic              flush,
    output logic [1:0]        gemm_uno,
    output logic              w_req,
    output logic              x_req,
    output logic [LEN_BW-1:0] x_idx,
    output logic              out_valid,
    output logic              busy,
    output logic              done
);

    localparam int W_BW = $clog2(NUM_PE + 1);

    seq_state_e        state_q;
    logic [1:0]        gemm_uno_q;
    logic [LEN_BW-1:0] len_q;
    logic [LEN_BW-1:0] x_idx_q;
    logic [W_BW-1:0]   w_cnt_q;
    logic              w_req_q;
    logic              x_req_q;
    logic              busy_q;
    logic              done_q;
    logic              dly_empty;

    // NOTE: all state lives in this one clocked block and uses non-blocking
    // assignments, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gemm_uno_q <= OP_GEMM;
            len_q      <= '0;
            x_idx_q    <= '0;
            w_cnt_q    <= '0;
            w_req_q    <= 1'b0;
            x_req_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else if (flush && state_q != IDLE) begin
            // Abort without a done pulse; gemm_uno deliberately keeps its value.
            state_q <= IDLE;
            x_idx_q <= '0;
            w_cnt_q <= '0;
            w_req_q <= 1'b0;
            x_req_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cmd_valid && !flush) begin
                        gemm_uno_q <= cmd_op;
                        len_q      <= cmd_len;
                        busy_q     <= 1'b1;
                        if (cmd_len == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else if (cmd_op == OP_GEMM) begin
                            state_q <= LOAD_W;
                            w_req_q <= 1'b1;
                            w_cnt_q <= '0;
                        end else begin
                            state_q <= STREAM;
                            x_req_q <= 1'b1;
                            x_idx_q <= '0;
                        end
                    end
                end
                LOAD_W: begin
                    if (w_cnt_q == W_BW'(NUM_PE - 1)) begin
                        state_q <= STREAM;
                        w_req_q <= 1'b0;
                        x_req_q <= 1'b1;
                        x_idx_q <= '0;
                    end else begin
                        w_cnt_q <= w_cnt_q + 1'b1;
                    end
                end
                STREAM: begin
                    // Compare against len-1 so the full 2^LEN_BW-1 count never wraps.
                    if (x_idx_q == len_q - 1'b1) begin
                        state_q <= DRAIN;
                        x_req_q <= 1'b0;
                        x_idx_q <= '0;
                    end else begin
                        x_idx_q <= x_idx_q + 1'b1;
                    end
                end
                DRAIN: begin
                    if (dly_empty) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    valid_dly #(
        .NUM_PE (NUM_PE),
        .UNO_LAT(UNO_LAT)
    ) u_valid_dly (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (flush),
        .din  (x_req_q),
        .uno  (gemm_uno_q != OP_GEMM),
        .dout (out_valid),
        .empty(dly_empty)
    );

    assign cmd_ready = (state_q == IDLE);
    assign gemm_uno  = gemm_uno_q;
    assign w_req     = w_req_q;
    assign x_req     = x_req_q;
    assign x_idx     = x_idx_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_raven_pe_seq.sv
// Directed bench for raven_pe_seq: per-cycle trace checks from a vector table
// plus hand-written flush, back-to-back and reset sequences.
module tb_raven_pe_seq;
    import raven_ctrl_pkg::*;

    typedef struct {
        logic [1:0] op;
        int         len;
        int         wf, wl;   // w_req cycle range (wl < wf means none)
        int         xf, xl;   // x_req cycle range
        int         vf, vl;   // out_valid cycle range
        int         dn;       // done cycle
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [9:0] cmd_len = '0;
    logic       flush = 1'b0;
    logic [1:0] gemm_uno;
    logic       w_req, x_req, out_valid, busy, done;
    logic [9:0] x_idx;

    int n_cmp = 0;
    int n_err = 0;

    raven_pe_seq #(.NUM_PE(8), .UNO_LAT(1), .LEN_BW(10)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .cmd_len  (cmd_len),
        .flush    (flush),
        .gemm_uno (gemm_uno),
        .w_req    (w_req),
        .x_req    (x_req),
        .x_idx    (x_idx),
        .out_valid(out_valid),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Packed view: {cmd_ready, busy, done, w_req, x_req, out_valid, gemm_uno, x_idx}
    function automatic logic [17:0] act_pack();
        return {cmd_ready, busy, done, w_req, x_req, out_valid, gemm_uno, x_idx};
    endfunction

    function automatic logic [17:0] idle_pack(input logic [1:0] gu);
        return {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, gu, 10'd0};
    endfunction

    function automatic logic [17:0] exp_pack(input vec_t v, input int c);
        logic w, x, ov, dn, bz, rdy;
        logic [9:0] idx;
        w   = (c >= v.wf) && (c <= v.wl);
        x   = (c >= v.xf) && (c <= v.xl);
        ov  = (c >= v.vf) && (c <= v.vl);
        dn  = (c == v.dn);
        bz  = (c <= v.dn);
        rdy = (c > v.dn);
        idx = x ? 10'(c - v.xf) : 10'd0;
        return {rdy, bz, dn, w, x, ov, v.op, idx};
    endfunction

    task automatic check(input string name, input logic [17:0] act, input logic [17:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got rdy/busy/done/w/x/ov/gu/idx=%b_%b_%b_%b_%b_%b_%b_%0d expected %b_%b_%b_%b_%b_%b_%b_%0d",
                     name, act[17], act[16], act[15], act[14], act[13], act[12], act[11:10], act[9:0],
                     expv[17], expv[16], expv[15], expv[14], expv[13], expv[12], expv[11:10], expv[9:0]);
        end
    endtask

    // Called at posedge+1 of cycle 0; returns at posedge+1 of cycle 1.
    task automatic issue(input logic [1:0] op, input int len);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_len   = len[9:0];
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    // Starts in cycle 1 of a command; ends in the second IDLE cycle after done.
    task automatic trace(input string tag, input vec_t v);
        for (int c = 1; c <= v.dn + 1; c++) begin
            check($sformatf("%s c%0d", tag, c), act_pack(), exp_pack(v, c));
            @(posedge clk);
            #1;
        end
    endtask

    vec_t vecs[6];
    vec_t v_big, v_exp2, v_div2, v_log2, v_gemm4, v_exp3;

    initial begin
        vecs[0] = '{OP_GEMM, 4, 1, 8, 9, 12, 17, 20, 21};
        vecs[1] = '{OP_EXP,  3, 0, -1, 1, 3, 10, 12, 13};
        vecs[2] = '{OP_DIV,  0, 0, -1, 0, -1, 0, -1, 1};
        vecs[3] = '{OP_LOG,  1, 0, -1, 1, 1, 10, 10, 11};
        vecs[4] = '{OP_GEMM, 1, 1, 8, 9, 9, 17, 17, 18};
        vecs[5] = '{OP_DIV,  5, 0, -1, 1, 5, 10, 14, 15};
        v_big   = '{OP_GEMM, 1023, 1, 8, 9, 1031, 17, 1039, 1040};
        v_exp2  = '{OP_EXP,  2, 0, -1, 1, 2, 10, 11, 12};
        v_div2  = '{OP_DIV,  2, 0, -1, 1, 2, 10, 11, 12};
        v_log2  = '{OP_LOG,  2, 0, -1, 1, 2, 10, 11, 12};
        v_gemm4 = vecs[0];
        v_exp3  = vecs[1];

        // Reset state
        #2;
        check("reset_state", act_pack(), idle_pack(OP_GEMM));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_idle", act_pack(), idle_pack(OP_GEMM));

        // Table-driven single commands
        foreach (vecs[i]) begin
            issue(vecs[i].op, vecs[i].len);
            trace($sformatf("vec%0d", i), vecs[i]);
        end

        // Maximum length streams fully without wrapping
        issue(v_big.op, v_big.len);
        trace("maxlen", v_big);

        // Flush during STREAM (cycle 10), then a new command in cycle 11
        issue(v_gemm4.op, v_gemm4.len);
        for (int c = 1; c <= 10; c++) begin
            check($sformatf("flush_pre c%0d", c), act_pack(), exp_pack(v_gemm4, c));
            if (c == 10) flush = 1'b1;
            @(posedge clk);
            #1;
        end
        flush = 1'b0;
        check("flush_c11_idle", act_pack(), idle_pack(OP_GEMM));
        issue(v_exp2.op, v_exp2.len);
        trace("after_flush", v_exp2);

        // flush and cmd_valid together in IDLE: flush wins
        flush     = 1'b1;
        cmd_valid = 1'b1;
        cmd_op    = OP_DIV;
        cmd_len   = 10'd3;
        @(posedge clk);
        #1;
        flush     = 1'b0;
        cmd_valid = 1'b0;
        check("flush_idle_c1", act_pack(), idle_pack(OP_EXP));
        @(posedge clk);
        #1;
        check("flush_idle_c2", act_pack(), idle_pack(OP_EXP));

        // Back-to-back with cmd_valid held: div then log
        cmd_valid = 1'b1;
        cmd_op    = OP_DIV;
        cmd_len   = 10'd2;
        @(posedge clk);
        #1;
        cmd_op = OP_LOG;
        for (int c = 1; c <= 13; c++) begin
            check($sformatf("b2b_div c%0d", c), act_pack(), exp_pack(v_div2, c));
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        trace("b2b_log", v_log2);

        // Asynchronous reset in the middle of STREAM
        issue(v_exp3.op, v_exp3.len);
        @(posedge clk);
        #1;
        check("rst_pre", act_pack(), exp_pack(v_exp3, 2));
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async", act_pack(), idle_pack(OP_GEMM));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_release", act_pack(), idle_pack(OP_GEMM));
        repeat (12) @(posedge clk);
        #1;
        check("rst_no_stale", act_pack(), idle_pack(OP_GEMM));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Stale out_valid after the mid-STREAM reset would be a fault.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && !busy && out_valid) begin
            n_cmp++;
            n_err++;
            $display("FAIL idle_out_valid: got out_valid=1 expected 0 while idle at %0t", $time);
        end
    end

endmodule

// File: doc/raven_pe_seq.md
# raven_pe_seq

Command-driven sequencer for one row of `NUM_PE` chained RAVEN processing elements. It accepts an operation command (GEMM, div, exp or log) and drives the row's mode select. For GEMM it first preloads the weight/coefficient chain. It then streams input vectors and tracks the pipeline latency so it can flag valid results at the row output and signal completion. It sits between the tile-level command queue and the PE row, beside the input and weight buffers it strobes.

## Interface
- `NUM_PE`, default 8: PEs in the chain. Also the weight-preload length and the GEMM result latency.
- `UNO_LAT`, default 1: extra latency of unary modes, contributed by the scale/offset generator registers.
- `LEN_BW`, default 10: width of the vector-count field.
- `clk` in 1: clock.
- `rst_n` in 1: reset; asynchronous, active-low.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: command accepted when `cmd_valid && cmd_ready`.
- `cmd_op` in 2: 00 gemm, 01 div, 10 exp, 11 log.
- `cmd_len` in LEN_BW: number of input vectors to stream.
- `flush` in 1: synchronous abort.
- `gemm_uno` out 2: mode select to every PE in the row.
- `w_req` out 1: weight buffer pop; shifts one word into the wc chain.
- `x_req` out 1: input buffer pop.
- `x_idx` out LEN_BW: index of the vector popped this cycle.
- `out_valid` out 1: the row output holds a valid result this cycle.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle completion pulse.

## Operation
- States are IDLE, LOAD_W, STREAM, DRAIN and DONE.
- `cmd_ready` = (state == IDLE).
- On accept:
  - latch `cmd_op` into `gemm_uno` and latch `cmd_len`.
  - If `cmd_len == 0`, go to DONE.
  - Otherwise, op 00 goes to LOAD_W; any other op goes to STREAM.
- LOAD_W: `w_req` = 1 for exactly `NUM_PE` cycles, then go to STREAM.
- STREAM:
  - `x_req` = 1 for exactly `cmd_len` cycles.
  - `x_idx` counts 0..`cmd_len`-1 and is 0 whenever `x_req` = 0.
  - After the last pop, go to DRAIN.
- `out_valid` is `x_req` delayed by D cycles:
  - D = `NUM_PE` for gemm.
  - D = `NUM_PE` + `UNO_LAT` for unary ops.
  - D is selected from the latched `gemm_uno`.
- DRAIN: wait until the delay line is empty, i.e. the last `out_valid` has been emitted. Go to DONE in the cycle after the last `out_valid`.
- DONE: `done` = 1 for one cycle, then go to IDLE.
- `gemm_uno` changes only on command accept and otherwise holds, including across IDLE, DONE and `flush`.
- `flush`, in any state:
  - next cycle the state is IDLE and the delay line is cleared.
  - `w_req`, `x_req`, `out_valid` and `done` are 0 from the next cycle.
  - No `done` pulse is produced.
- `flush` in IDLE is a no-op. If `flush` and `cmd_valid` are both high in IDLE, `flush` wins and the command is not accepted.
- The length counter is LEN_BW wide. `cmd_len` = 2^LEN_BW-1 must stream fully, with no wrap before completion.

## Timing
- Reset values:
  - state IDLE.
  - `gemm_uno` = 00.
  - `w_req`, `x_req`, `x_idx`, `out_valid`, `busy`, `done` = 0.
  - `cmd_ready` = 1.
  - delay line cleared.
- Cycle numbering: the accept edge ends cycle 0.
  - The new `gemm_uno` is visible from cycle 1.
  - The first `w_req` (gemm) or `x_req` (unary) is in cycle 1.
- All outputs except `cmd_ready` are registered or decoded from registered state; none depends combinationally on `cmd_valid` or `flush`.
- Back-to-back commands: the next accept is possible in the first IDLE cycle, one cycle after `done`.

## Structure
- Package `raven_ctrl_pkg` holds:
  - `typedef enum logic [2:0] seq_state_e` (IDLE, LOAD_W, STREAM, DRAIN, DONE).
  - op constants `OP_GEMM`, `OP_DIV`, `OP_EXP`, `OP_LOG` (2-bit).
- Sub-module `valid_dly`:
  - a shift register of depth `NUM_PE` + `UNO_LAT` with synchronous clear.
  - output tap selected by a 1-bit `uno` input.
  - an `empty` flag for the DRAIN exit.

## Test plan
- Reset check: with `rst_n` low mid-STREAM, all outputs go to their reset values immediately. After release, `cmd_ready` = 1 and `gemm_uno` = 00.
- GEMM, `NUM_PE` = 8, `cmd_len` = 4:
  - `w_req` in cycles 1–8.
  - `x_req` in cycles 9–12 with `x_idx` 0–3.
  - `out_valid` in cycles 17–20.
  - `done` in cycle 21.
  - `cmd_ready` in cycle 22.
- Exp (op 10), `cmd_len` = 3, `UNO_LAT` = 1:
  - no `w_req`.
  - `x_req` in cycles 1–3.
  - `out_valid` in cycles 10–12.
  - `done` in cycle 13.
  - `gemm_uno` = 10 from cycle 1.
- `cmd_len` = 0, op 01: `gemm_uno` = 01 from cycle 1, `done` in cycle 1, no `w_req`/`x_req`/`out_valid`, `cmd_ready` in cycle 2.
- `flush` in cycle 10 of the GEMM case above:
  - from cycle 11: state IDLE, `x_req`/`out_valid` = 0, no `done` pulse, `gemm_uno` still 00.
  - a new command is accepted in cycle 11.
- Back-to-back: `cmd_valid` held high with ops div then log (`cmd_len` = 2 each). The second command is accepted in the cycle after the first `done`, and `gemm_uno` switches 01→11 exactly then.
